// File: rtl/regfile_ctrl_pkg.sv
// rtl/regfile_ctrl_pkg.sv - shared types and constants for the register file write-port controller
//
// Contents:
//   NUM_REGS, REG_ADDR_W : register file geometry (16 entries, 4-bit address)
//   WB_DATA_WIDTH        : MSB index of the writeback data word carried in wb_req_t
//   src_e                : writeback source encoding, used for the round-robin pointer and grants
//   wb_req_t             : one writeback request {valid, dest, data}

package regfile_ctrl_pkg;

    localparam int NUM_REGS      = 16;
    localparam int REG_ADDR_W    = 4;
    localparam int WB_DATA_WIDTH = 31;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    // "reg" is a keyword, so the destination field is called dest.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dest;
        logic [WB_DATA_WIDTH:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter with combinational grant
//
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous reset, active-high; forces gnt=0 and pointer to SRC_ALU
//   req[1:0] : requests, bit 0 = ALU, bit 1 = MEM
//   advance  : move the pointer past the granted source at the next edge
//   gnt[1:0] : one-hot (or zero) grant, combinational from req and the pointer

module rr_arbiter2
    import regfile_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    src_e ptr;

    // The pointer only matters when both sources request at once.
    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (ptr == SRC_ALU) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    // After a grant the other source gets priority; with no grant the pointer holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= SRC_ALU;
        end else if (advance && (gnt != 2'b00)) begin
            ptr <= gnt[0] ? SRC_MEM : SRC_ALU;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register file write port between ALU and load writebacks
//
// Ports:
//   clk, rst                        : clock (rising edge), synchronous active-high reset
//   alu_valid/alu_ready/alu_reg/alu_data : ALU writeback request, ready is combinational
//   mem_valid/mem_ready/mem_reg/mem_data : load writeback request, ready is combinational
//   rsv_valid/rsv_reg               : issue stage reserves a destination register
//   busy                            : registered scoreboard, bit r = write pending on register r
//   wr_enable/wr_reg/wr_data        : registered register file write port, one cycle after grant
//   rsv_conflict                    : one-cycle pulse, reservation hit an already-busy register
//   wr_unreserved                   : one-cycle pulse, accepted write targeted a non-busy register

module regfile_wb_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 31,
    parameter int NUM_REGS   = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_reg,
    input  logic [DATA_WIDTH:0]   alu_data,

    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] mem_reg,
    input  logic [DATA_WIDTH:0]   mem_data,

    input  logic                  rsv_valid,
    input  logic [REG_ADDR_W-1:0] rsv_reg,

    output logic [NUM_REGS-1:0]   busy,
    output logic                  wr_enable,
    output logic [REG_ADDR_W-1:0] wr_reg,
    output logic [DATA_WIDTH:0]   wr_data,
    output logic                  rsv_conflict,
    output logic                  wr_unreserved
);

    wb_req_t alu_req;
    wb_req_t mem_req;
    logic [1:0] gnt;
    logic grant_any;
    logic [REG_ADDR_W-1:0] grant_reg;
    logic [WB_DATA_WIDTH:0] grant_data;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] busy_next;

    always_comb begin
        alu_req.valid = alu_valid;
        alu_req.dest  = alu_reg;
        alu_req.data  = (WB_DATA_WIDTH+1)'(alu_data);
        mem_req.valid = mem_valid;
        mem_req.dest  = mem_reg;
        mem_req.data  = (WB_DATA_WIDTH+1)'(mem_data);
    end

    // The register file never stalls, so any valid request is granted this cycle.
    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({mem_req.valid, alu_req.valid}),
        .advance (grant_any),
        .gnt     (gnt)
    );

    assign alu_ready = gnt[0];
    assign mem_ready = gnt[1];
    assign grant_any = alu_ready | mem_ready;

    always_comb begin
        grant_reg  = mem_ready ? mem_req.dest : alu_req.dest;
        grant_data = mem_ready ? mem_req.data : alu_req.data;
    end

    // A reservation and a release of the same register at one edge leaves it busy:
    // the set term is OR-ed in after the clear, so the new producer owns the register.
    always_comb begin
        set_mask  = '0;
        clr_mask  = '0;
        if (rsv_valid) set_mask[rsv_reg]   = 1'b1;
        if (grant_any) clr_mask[grant_reg] = 1'b1;
        busy_next = (busy & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy          <= '0;
            wr_enable     <= 1'b0;
            wr_reg        <= '0;
            wr_data       <= '0;
            rsv_conflict  <= 1'b0;
            wr_unreserved <= 1'b0;
        end else begin
            busy      <= busy_next;
            wr_enable <= grant_any;
            if (grant_any) begin
                wr_reg  <= grant_reg;
                wr_data <= (DATA_WIDTH+1)'(grant_data);
            end
            // A reservation is only a conflict if the register stays busy through
            // this edge; a same-edge release hands it straight to the new producer.
            rsv_conflict  <= rsv_valid && busy[rsv_reg] &&
                             !(grant_any && (grant_reg == rsv_reg));
            wr_unreserved <= grant_any && !busy[grant_reg];
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter

module tb_regfile_wb_arbiter;

    import regfile_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [3:0]  alu_reg;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_reg;
    logic [31:0] mem_data;
    logic        rsv_valid;
    logic [3:0]  rsv_reg;
    logic [15:0] busy;
    logic        wr_enable;
    logic [3:0]  wr_reg;
    logic [31:0] wr_data;
    logic        rsv_conflict;
    logic        wr_unreserved;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DATA_WIDTH(31), .NUM_REGS(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_reg       (alu_reg),
        .alu_data      (alu_data),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_reg       (mem_reg),
        .mem_data      (mem_data),
        .rsv_valid     (rsv_valid),
        .rsv_reg       (rsv_reg),
        .busy          (busy),
        .wr_enable     (wr_enable),
        .wr_reg        (wr_reg),
        .wr_data       (wr_data),
        .rsv_conflict  (rsv_conflict),
        .wr_unreserved (wr_unreserved)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle 1ns past it; inputs are driven and outputs sampled there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        alu_valid = 1'b1; alu_reg = 4'd0; alu_data = 32'h0;
        mem_valid = 1'b0; mem_reg = 4'd0; mem_data = 32'h0;
        rsv_valid = 1'b0; rsv_reg = 4'd0;

        // 1. reset: ready held low while rst is high
        #1;
        chk("rst_alu_ready_0", 32'(alu_ready), 32'd0);
        tick();
        chk("rst_alu_ready_1", 32'(alu_ready), 32'd0);
        tick();
        rst = 1'b0;
        alu_valid = 1'b0;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_wr_enable", 32'(wr_enable), 32'd0);
        chk("rst_wr_reg", 32'(wr_reg), 32'd0);
        chk("rst_wr_data", wr_data, 32'h0);
        chk("rst_flags", {30'd0, rsv_conflict, wr_unreserved}, 32'd0);

        // 2. single reserved ALU write
        rsv_valid = 1'b1; rsv_reg = 4'd5;
        tick();
        rsv_valid = 1'b0;
        chk("rsv5_busy", 32'(busy), 32'h0020);
        alu_valid = 1'b1; alu_reg = 4'd5; alu_data = 32'hDEADBEEF;
        #1;
        chk("alu5_ready", 32'(alu_ready), 32'd1);
        chk("alu5_mem_ready", 32'(mem_ready), 32'd0);
        tick();
        alu_valid = 1'b0;
        chk("alu5_wr_enable", 32'(wr_enable), 32'd1);
        chk("alu5_wr_reg", 32'(wr_reg), 32'd5);
        chk("alu5_wr_data", wr_data, 32'hDEADBEEF);
        chk("alu5_busy", 32'(busy), 32'h0);
        chk("alu5_unreserved", 32'(wr_unreserved), 32'd0);
        tick();
        chk("idle_wr_enable", 32'(wr_enable), 32'd0);
        chk("idle_wr_reg_hold", 32'(wr_reg), 32'd5);
        chk("idle_wr_data_hold", wr_data, 32'hDEADBEEF);

        // pointer sits on MEM after the ALU grant; a lone MEM write hands it back to ALU
        mem_valid = 1'b1; mem_reg = 4'd10; mem_data = 32'h10;
        tick();
        mem_valid = 1'b0;
        chk("mem10_wr_reg", 32'(wr_reg), 32'd10);

        // 3. contention: ALU reg 1 vs MEM reg 2 alternate, one write per cycle
        alu_valid = 1'b1; alu_reg = 4'd1; alu_data = 32'h111;
        mem_valid = 1'b1; mem_reg = 4'd2; mem_data = 32'h222;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("cont%0d_alu_ready", i), 32'(alu_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("cont%0d_mem_ready", i), 32'(mem_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
            tick();
            if (i == 3) begin
                alu_valid = 1'b0;
                mem_valid = 1'b0;
            end
            chk($sformatf("cont%0d_wr_enable", i), 32'(wr_enable), 32'd1);
            chk($sformatf("cont%0d_wr_reg", i), 32'(wr_reg), (i % 2 == 0) ? 32'd1 : 32'd2);
            chk($sformatf("cont%0d_wr_data", i), wr_data, (i % 2 == 0) ? 32'h111 : 32'h222);
        end
        tick();
        chk("cont_end_wr_enable", 32'(wr_enable), 32'd0);

        // 4. same-edge set and clear of reg 3
        rsv_valid = 1'b1; rsv_reg = 4'd3;
        tick();
        rsv_valid = 1'b0;
        chk("rsv3_busy", 32'(busy), 32'h0008);
        mem_valid = 1'b1; mem_reg = 4'd3; mem_data = 32'h33;
        rsv_valid = 1'b1; rsv_reg = 4'd3;
        #1;
        chk("setclr_mem_ready", 32'(mem_ready), 32'd1);
        tick();
        mem_valid = 1'b0;
        rsv_valid = 1'b0;
        chk("setclr_busy", 32'(busy), 32'h0008);
        chk("setclr_conflict", 32'(rsv_conflict), 32'd0);
        chk("setclr_wr_enable", 32'(wr_enable), 32'd1);
        chk("setclr_wr_reg", 32'(wr_reg), 32'd3);
        chk("setclr_wr_data", wr_data, 32'h33);
        chk("setclr_unreserved", 32'(wr_unreserved), 32'd0);

        // 5a. double reservation of reg 7
        rsv_valid = 1'b1; rsv_reg = 4'd7;
        tick();
        chk("rsv7a_conflict", 32'(rsv_conflict), 32'd0);
        chk("rsv7a_busy", 32'(busy), 32'h0088);
        tick();
        rsv_valid = 1'b0;
        chk("rsv7b_conflict", 32'(rsv_conflict), 32'd1);
        chk("rsv7b_busy", 32'(busy), 32'h0088);
        tick();
        chk("rsv7c_conflict", 32'(rsv_conflict), 32'd0);

        // 5b. write to an unreserved register
        alu_valid = 1'b1; alu_reg = 4'd9; alu_data = 32'h99;
        tick();
        alu_valid = 1'b0;
        chk("unres9_flag", 32'(wr_unreserved), 32'd1);
        chk("unres9_wr_enable", 32'(wr_enable), 32'd1);
        chk("unres9_wr_reg", 32'(wr_reg), 32'd9);
        tick();
        chk("unres9_flag_clear", 32'(wr_unreserved), 32'd0);

        // 6. reset during a MEM grant cycle; pointer was on MEM and must return to ALU
        mem_valid = 1'b1; mem_reg = 4'd4; mem_data = 32'h44;
        rst = 1'b1;
        #1;
        chk("rstmid_mem_ready", 32'(mem_ready), 32'd0);
        tick();
        rst = 1'b0;
        mem_valid = 1'b0;
        chk("rstmid_wr_enable", 32'(wr_enable), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'h0);
        alu_valid = 1'b1; alu_reg = 4'd11; alu_data = 32'hB;
        mem_valid = 1'b1; mem_reg = 4'd12; mem_data = 32'hC;
        #1;
        chk("post_rst_alu_ready", 32'(alu_ready), 32'd1);
        chk("post_rst_mem_ready", 32'(mem_ready), 32'd0);
        tick();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        chk("post_rst_wr_reg", 32'(wr_reg), 32'd11);
        chk("post_rst_wr_data", wr_data, 32'hB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
